mm_act_feeder: RTL and testbench
================================

# mm_act_feeder

Parametrised activation feeder for the FP-INT matrix-multiply array: it buffers N-wide activation vectors and replays each word for `precision` cycles, matching the bit-serial weight stream. Each row's output is skewed by its row index so the stream enters the systolic array diagonally. It replaces the per-row activation FIFOs inside `mm` and adds shared pointers, runtime precision clamping, diagonal skew, overflow flagging and a drain-complete pulse.

## Interface
- `ACT_WIDTH`, 16, width of one FP16 activation word
- `N`, 4, number of array rows (channels), ≥1
- `DEPTH`, 16, vector entries buffered; power of two, ≥2
- `PREC_MAX`, 8, largest supported weight precision (1..15)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `precision` in 4: weight bits per activation word
- `wr_en` in 1: write one vector
- `din` in N*ACT_WIDTH: vector; row r at bits [r*ACT_WIDTH +: ACT_WIDTH]
- `active` in 1: read enable / run
- `act_out` out N*ACT_WIDTH: registered, skewed row words
- `act_valid` out N: per-row valid
- `full` out 1: DEPTH vectors held
- `empty` out 1: no vectors held
- `overflow` out 1: sticky, write attempted while full
- `done` out 1: one-cycle drain-complete pulse

## Operation
- Storage: one DEPTH×(N*ACT_WIDTH) buffer, shared wr/rd pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Write: if `wr_en` and not `full`, store `din` at wr_ptr, then increment. If `wr_en` and `full`, discard the write and set `overflow`. `overflow` clears only on reset.
- Effective precision P: `precision` 0 → 1; `precision` > PREC_MAX → PREC_MAX. P is latched when beat = 0 and a word starts, and holds for the whole word.
- Beat: when `active` and not `empty`, the head vector is issued and the beat counter advances. At beat P-1 the vector is popped (rd_ptr+1, count-1) and beat returns to 0. When `active` is low, or the buffer is empty, the beat counter holds and no beat issues (a bubble).
- Skew: row 0 registers the issued word/valid. Row r passes through r further register stages. Skew stages advance every cycle, including bubbles. Row r is therefore an exact copy of row 0 delayed by r cycles.
- Simultaneous push and pop: count unchanged and both pointers move. A push on a full buffer during the pop cycle is still rejected, because `full` is evaluated at cycle start.
- Drain: `done` pulses for exactly one cycle, on the cycle after the last valid beat leaves row N-1, when the buffer is empty and no skew stage holds a valid beat.
- Reset, at any time including mid-word: pointers, count, beat and latched P go to 0, all skew stages are cleared. Outputs: `act_out`=0, `act_valid`=0, `full`=0, `empty`=1, `overflow`=0, `done`=0.

## Timing
- Write at edge t: `empty` falls and `full` updates after edge t (registered flags).
- Read latency: with `active`=1 and `empty`=0 in cycle c, row 0 `act_valid`/`act_out` are valid from cycle c+1. Row r is valid from cycle c+1+r.
- Per-word occupancy: each word shows on its row for P consecutive valid cycles when `active` is held high.
- A pop at beat P-1 frees a slot visible in `full` on the next cycle.
- `done` comes N cycles after the final row-0 beat, assuming no stalls.

## Test plan
- Reset: hold `rst`=0 mid-stream → all outputs at reset values, `empty`=1. After release, a new stream runs cleanly.
- Basic skew, N=2, P=4: write {0x3C00,0x4000} then {0xBC00,0xC000}; hold `active` → row 0: 0x3C00 ×4 then 0xBC00 ×4. Row 1: 0x4000 ×4 then 0xC000 ×4, one cycle later. `done` pulses once, 2 cycles after the last row-0 beat.
- Precision clamp: `precision`=0 → each word valid 1 cycle. `precision`=12 with PREC_MAX=8 → each word valid 8 cycles.
- Stall: drop `active` for 2 cycles at beat 2 → row 0 shows a 2-cycle `act_valid`=0 bubble, then the same word for the remaining 2 beats. The bubble appears on row 1 one cycle later.
- Full/overflow, DEPTH=4: 5 writes → `full`=1 after the 4th, the 5th is discarded, `overflow`=1. The read order is the first 4 vectors. Pointer wrap is verified by refilling after the drain.
- Simultaneous push/pop at count 2 → count stays 2, data order preserved.

Source files
------------

// File: rtl/mm_act_feeder.sv
// Activation feeder for the FP-INT matmul array: buffers N-wide activation vectors,
// replays each word for P beats and skews row r by r cycles so the stream enters diagonally.
module mm_act_feeder #(
    parameter int ACT_WIDTH = 16,
    parameter int N         = 4,
    parameter int DEPTH     = 16,
    parameter int PREC_MAX  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             precision,
    input  logic                   wr_en,
    input  logic [N*ACT_WIDTH-1:0] din,
    input  logic                   active,
    output logic [N*ACT_WIDTH-1:0] act_out,
    output logic [N-1:0]           act_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = N * ACT_WIDTH;
    localparam logic [3:0]    P_MAX   = 4'(PREC_MAX);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [VW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [3:0]    beat_reg;
    logic [3:0]    p_reg;
    logic [3:0]    p_clamp;
    logic [3:0]    p_cur;
    logic          full_reg;
    logic          empty_reg;
    logic          overflow_reg;
    logic          done_reg;
    logic          push;
    logic          pop;
    logic          issue;
    logic          last_beat;
    logic          done_next;
    logic [N-1:0]  vld_reg;
    logic [N-1:0]  vld_next;
    logic [VW-1:0] row0_reg;

    always_comb begin
        p_clamp = precision;
        if (precision == 4'd0) begin
            p_clamp = 4'd1;
        end else if (precision > P_MAX) begin
            p_clamp = P_MAX;
        end
    end

    // A new word takes the live precision; a word in flight keeps the one it started with.
    assign p_cur     = (beat_reg == 4'd0) ? p_clamp : p_reg;
    assign issue     = active && !empty_reg;
    assign last_beat = (beat_reg == p_cur - 4'd1);
    assign push      = wr_en && !full_reg;
    assign pop       = issue && last_beat;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_comb begin
        vld_next    = '0;
        vld_next[0] = issue;
        for (int k = 1; k < N; k++) begin
            vld_next[k] = vld_reg[k-1];
        end
    end

    // Drain completes when the last row's final beat retires and nothing is left behind it.
    assign done_next = vld_reg[N-1] && (vld_next == '0) && (count_next == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            beat_reg     <= '0;
            p_reg        <= '0;
            vld_reg      <= '0;
            row0_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && full_reg) begin
                overflow_reg <= 1'b1;
            end
            if (issue) begin
                if (beat_reg == 4'd0) begin
                    p_reg <= p_clamp;
                end
                beat_reg <= last_beat ? 4'd0 : beat_reg + 4'd1;
            end
            vld_reg  <= vld_next;
            row0_reg <= issue ? mem[rd_ptr_reg] : '0;
            done_reg <= done_next;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        if (gi == 0) begin : g_head
            assign act_out[0 +: ACT_WIDTH] = row0_reg[0 +: ACT_WIDTH];
        end else begin : g_skew
            // Row gi trails row 0 by gi stages; stages shift every cycle, bubbles included.
            logic [ACT_WIDTH-1:0] skew_reg [gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < gi; k++) begin
                        skew_reg[k] <= '0;
                    end
                end else begin
                    skew_reg[0] <= row0_reg[gi*ACT_WIDTH +: ACT_WIDTH];
                    for (int k = 1; k < gi; k++) begin
                        skew_reg[k] <= skew_reg[k-1];
                    end
                end
            end

            assign act_out[gi*ACT_WIDTH +: ACT_WIDTH] = skew_reg[gi-1];
        end
    end

    assign act_valid = vld_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign overflow  = overflow_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_mm_act_feeder.sv
// Self-checking bench for mm_act_feeder (N=2, DEPTH=4): per-row scoreboard of expected
// words plus per-scenario timing checks on latency, skew, bubbles, flags and drain pulse.
module tb_mm_act_feeder;
    localparam int AW = 16;
    localparam int NR = 2;
    localparam int DP = 4;
    localparam int PM = 8;

    logic           clk;
    logic           rst;
    logic [3:0]     precision;
    logic           wr_en;
    logic [NR*AW-1:0] din;
    logic           active;
    logic [NR*AW-1:0] act_out;
    logic [NR-1:0]  act_valid;
    logic           full;
    logic           empty;
    logic           overflow;
    logic           done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [AW-1:0] exp_q0 [$];
    logic [AW-1:0] exp_q1 [$];
    int first_v [NR];
    int last_v  [NR];
    int done_cnt;
    int done_cyc;
    logic [AW-1:0] mon_got;
    logic [AW-1:0] mon_exp;

    mm_act_feeder #(
        .ACT_WIDTH(AW),
        .N(NR),
        .DEPTH(DP),
        .PREC_MAX(PM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .precision(precision),
        .wr_en(wr_en),
        .din(din),
        .active(active),
        .act_out(act_out),
        .act_valid(act_valid),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid beat on a row must match the next expected word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int r = 0; r < NR; r++) begin
                if (act_valid[r] === 1'b1) begin
                    mon_got = act_out[r*AW +: AW];
                    checks++;
                    if ((r == 0 && exp_q0.size() == 0) || (r == 1 && exp_q1.size() == 0)) begin
                        failures++;
                        $display("FAIL sb_row%0d_extra cycle=%0d got=%h expected=none", r, cyc, mon_got);
                    end else begin
                        if (r == 0) mon_exp = exp_q0.pop_front();
                        else        mon_exp = exp_q1.pop_front();
                        if (mon_got !== mon_exp) begin
                            failures++;
                            $display("FAIL sb_row%0d_data cycle=%0d got=%h expected=%h", r, cyc, mon_got, mon_exp);
                        end
                    end
                    if (first_v[r] < 0) first_v[r] = cyc;
                    last_v[r] = cyc;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        for (int r = 0; r < NR; r++) begin
            first_v[r] = -1;
            last_v[r]  = -1;
        end
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic push_vec(input logic [31:0] v, input int p, input bit accept);
        wr_en = 1'b1;
        din   = v;
        if (accept) begin
            for (int k = 0; k < p; k++) begin
                exp_q0.push_back(v[15:0]);
                exp_q1.push_back(v[31:16]);
            end
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; active = 1'b0; precision = 4'd4; din = '0;
        #12;
        checks++; if (act_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b expected=00", act_valid); end
        checks++; if (act_out !== 32'h0) begin failures++; $display("FAIL reset_act_out got=%h expected=0", act_out); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b expected empty=1 full=0", empty, full); end
        checks++; if (overflow !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_ovf_done got overflow=%b done=%b expected 0 0", overflow, done); end
        tick();
        rst = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_basic_skew();
        int a;
        clear_marks();
        precision = 4'd4; active = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL skew_empty_before got=%b expected=1", empty); end
        push_vec(32'h4000_3C00, 4, 1'b1);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL skew_empty_after_write got=%b expected=0", empty); end
        push_vec(32'hC000_BC00, 4, 1'b1);
        active = 1'b1; a = cyc;
        wait_drain();
        active = 1'b0;
        checks++; if (first_v[0] != a + 1) begin failures++; $display("FAIL skew_row0_first got=%0d expected=%0d", first_v[0], a + 1); end
        checks++; if (last_v[0] != a + 8) begin failures++; $display("FAIL skew_row0_last got=%0d expected=%0d", last_v[0], a + 8); end
        checks++; if (first_v[1] != a + 2) begin failures++; $display("FAIL skew_row1_first got=%0d expected=%0d", first_v[1], a + 2); end
        checks++; if (last_v[1] != a + 9) begin failures++; $display("FAIL skew_row1_last got=%0d expected=%0d", last_v[1], a + 9); end
        checks++; if (done_cnt != 1 || done_cyc != a + 10) begin failures++; $display("FAIL skew_done got count=%0d cycle=%0d expected count=1 cycle=%0d", done_cnt, done_cyc, a + 10); end
        checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL skew_sb_left got=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size()); end
        $display("test_basic_skew: start=%0d done_cycle=%0d", a, done_cyc);
    endtask

    task automatic test_precision_clamp();
        int a;
        clear_marks();
        precision = 4'd0; active = 1'b0;
        push_vec(32'h1234_5678, 1, 1'b1);
        push_vec(32'h9ABC_DEF0, 1, 1'b1);
        active = 1'b1; a = cyc;
        wait_drain();
        active = 1'b0;
        checks++; if (first_v[0] != a + 1 || last_v[0] != a + 2) begin failures++; $display("FAIL clamp0_row0_span got=%0d..%0d expected=%0d..%0d", first_v[0], last_v[0], a + 1, a + 2); end
        checks++; if (last_v[1] != a + 3) begin failures++; $display("FAIL clamp0_row1_last got=%0d expected=%0d", last_v[1], a + 3); end
        checks++; if (done_cyc != a + 4) begin failures++; $display("FAIL clamp0_done got=%0d expected=%0d", done_cyc, a + 4); end
        clear_marks();
        precision = 4'd12;
        push_vec(32'h0A0A_0B0B, 8, 1'b1);
        push_vec(32'h0C0C_0D0D, 8, 1'b1);
        active = 1'b1; a = cyc;
        wait_drain();
        active = 1'b0;
        checks++; if (first_v[0] != a + 1 || last_v[0] != a + 16) begin failures++; $display("FAIL clamp12_row0_span got=%0d..%0d expected=%0d..%0d", first_v[0], last_v[0], a + 1, a + 16); end
        checks++; if (done_cyc != a + 18) begin failures++; $display("FAIL clamp12_done got=%0d expected=%0d", done_cyc, a + 18); end
        checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL clamp_sb_left got=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size()); end
        $display("test_precision_clamp: start=%0d done_cycle=%0d", a, done_cyc);
    endtask

    task automatic test_stall();
        int a;
        bit r0 [7];
        bit r1 [7];
        r0 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        r1 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        clear_marks();
        precision = 4'd4; active = 1'b0;
        push_vec(32'h4400_4200, 4, 1'b1);
        active = 1'b1; a = cyc;
        for (int off = 1; off <= 7; off++) begin
            tick();
            active = !(off == 2 || off == 3);
            @(negedge clk);
            checks++;
            if (act_valid !== {r1[off-1], r0[off-1]}) begin
                failures++;
                $display("FAIL stall_valid offset=%0d got=%b expected=%b", off, act_valid, {r1[off-1], r0[off-1]});
            end
        end
        wait_drain();
        active = 1'b0;
        checks++; if (done_cnt != 1 || done_cyc != a + 8) begin failures++; $display("FAIL stall_done got count=%0d cycle=%0d expected count=1 cycle=%0d", done_cnt, done_cyc, a + 8); end
        checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL stall_sb_left got=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size()); end
        $display("test_stall: start=%0d done_cycle=%0d", a, done_cyc);
    endtask

    task automatic test_full_overflow();
        int a;
        logic [31:0] v;
        clear_marks();
        precision = 4'd1; active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = {16'h5100 + 16'(i), 16'h5000 + 16'(i)};
            push_vec(v, 1, 1'b1);
            checks++;
            if (full !== (i == 3)) begin failures++; $display("FAIL full_after_write%0d got=%b expected=%b", i + 1, full, (i == 3)); end
        end
        push_vec(32'hDEAD_BEEF, 1, 1'b0);
        checks++; if (overflow !== 1'b1 || full !== 1'b1) begin failures++; $display("FAIL overflow_set got overflow=%b full=%b expected 1 1", overflow, full); end
        active = 1'b1; a = cyc;
        tick();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_release got=%b expected=0", full); end
        wait_drain();
        active = 1'b0;
        checks++; if (done_cyc != a + 6) begin failures++; $display("FAIL full_done got=%0d expected=%0d", done_cyc, a + 6); end
        checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL full_sb_left got=%0d/%0d expected=0/0", exp_q0.size(), exp_q1.size()); end
        clear_marks();
        for (int i = 0; i < 3; i++) begin
            v = {16'h6100 + 16'(i), 16'h6000 + 16'(i)};
            push_vec(v, 1, 1'b1);
        end
        active = 1'b1;
        wait_drain();
        active = 1'b0;
        checks++; if (done_cnt != 1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL wrap_refill got done=%0d left=%0d/%0d expected done=1 left=0/0", done_cnt, exp_q0.size(), exp_q1.size()); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b expected=1", overflow); end
        $display("test_full_overflow: start=%0d done_cycle=%0d", a, done_cyc);
    endtask

    task automatic test_back_to_back();
        clear_marks();
        precision = 4'd1; active = 1'b0;
        push_vec(32'h7001_7000, 1, 1'b1);
        push_vec(32'h7011_7010, 1, 1'b1);
        active = 1'b1; wr_en = 1'b1; din = 32'h7021_7020;
        exp_q0.push_back(16'h7020);
        exp_q1.push_back(16'h7021);
        tick();
        wr_en = 1'b0; active = 1'b0;
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL b2b_flags got empty=%b full=%b expected 0 0", empty, full); end
        push_vec(32'h7031_7030, 1, 1'b1);
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL b2b_count3 got full=%b expected=0", full); end
        push_vec(32'h7041_7040, 1, 1'b1);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL b2b_count4 got full=%b expected=1", full); end
        active = 1'b1;
        wait_drain();
        active = 1'b0;
        checks++; if (done_cnt != 1 || exp_q0.size() != 0 || exp_q1.size() != 0) begin failures++; $display("FAIL b2b_drain got done=%0d left=%0d/%0d expected done=1 left=0/0", done_cnt, exp_q0.size(), exp_q1.size()); end
        $display("test_back_to_back: done_cycle=%0d", done_cyc);
    endtask

    task automatic test_reset_mid_stream();
        clear_marks();
        precision = 4'd4; active = 1'b0;
        push_vec(32'h1111_2222, 4, 1'b1);
        push_vec(32'h3333_4444, 4, 1'b1);
        active = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #2;
        exp_q0.delete();
        exp_q1.delete();
        checks++; if (act_valid !== 2'b00 || act_out !== 32'h0) begin failures++; $display("FAIL midrst_outputs got valid=%b out=%h expected 00 0", act_valid, act_out); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL midrst_flags got empty=%b full=%b expected 1 0", empty, full); end
        checks++; if (overflow !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ovf_done got overflow=%b done=%b expected 0 0", overflow, done); end
        active = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (empty !== 1'b1 || act_valid !== 2'b00) begin failures++; $display("FAIL midrst_release got empty=%b valid=%b expected 1 00", empty, act_valid); end
        $display("test_reset_mid_stream: done");
    endtask

    initial begin
        clear_marks();
        test_reset();
        test_basic_skew();
        test_precision_clamp();
        test_stall();
        test_full_overflow();
        test_back_to_back();
        test_reset_mid_stream();
        test_basic_skew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
